// File: rtl/sm3_msg_feeder.sv
// sm3_msg_feeder: message-word FIFO and input handshake driver for the SM3 core, with digest capture.
// Ports: clk, rst (async, active-high); write side wr_en/wr_data/wr_last/wr_nbyte, abort;
//   status fifo_full/fifo_cnt/ovf_err/busy/done/res; core side msg_inpt_d/_vld_byte/_vld/_lst,
//   msg_inpt_rdy, cmprss_otpt_res/_vld.
// Build option: define SM3_FEED_BSWAP_EN to byte-reverse wr_data on write (little-endian bus).
module sm3_msg_feeder #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       wr_last,
  input  logic [$clog2(DW/8)-1:0]    wr_nbyte,
  input  logic                       abort,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic                       ovf_err,
  output logic                       busy,
  output logic                       done,
  output logic [255:0]               res,
  output logic [DW-1:0]              msg_inpt_d,
  output logic [DW/8-1:0]            msg_inpt_vld_byte,
  output logic                       msg_inpt_vld,
  output logic                       msg_inpt_lst,
  input  logic                       msg_inpt_rdy,
  input  logic [255:0]               cmprss_otpt_res,
  input  logic                       cmprss_otpt_vld
);
  localparam int BW = DW / 8;
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_FEED = 2'd1, S_WAIT = 2'd2;
  logic [1:0]    r_st;
  logic [AW:0]   r_wp, r_rp;
  logic [DW-1:0] r_dat [DEPTH];
  logic          r_lst [DEPTH];
  logic [BW-1:0] r_msk [DEPTH];
  logic          r_done, r_ovf;
  logic [255:0]  r_res;
  logic [DW-1:0] w_wd;
  logic [BW-1:0] w_wm;
  logic [AW-1:0] w_hd;
  logic          w_empty, w_push, w_vld, w_pop;
`ifdef SM3_FEED_BSWAP_EN
  for (genvar i = 0; i < BW; i++) begin : g_sw
    assign w_wd[8*i +: 8] = wr_data[DW-8-8*i +: 8];
  end
`else
  assign w_wd = wr_data;
`endif
  // nbyte==0 on a last word means a full word; non-last words are always full
  assign w_wm    = (wr_last && wr_nbyte != '0) ? ~({BW{1'b1}} >> wr_nbyte) : '1;
  assign w_hd    = r_rp[AW-1:0];
  assign w_empty = r_wp == r_rp;
  assign fifo_cnt  = r_wp - r_rp;
  assign fifo_full = fifo_cnt == (AW+1)'(DEPTH);
  // full is the pre-pop value, so a push against a full FIFO is refused even if a pop happens
  assign w_push  = wr_en & ~fifo_full;
  assign w_vld   = (r_st == S_FEED) & ~w_empty;
  assign w_pop   = w_vld & msg_inpt_rdy;
  assign msg_inpt_vld      = w_vld;
  assign msg_inpt_d        = w_vld ? r_dat[w_hd] : '0;
  assign msg_inpt_vld_byte = w_vld ? r_msk[w_hd] : '0;
  assign msg_inpt_lst      = w_vld & r_lst[w_hd];
  assign busy    = r_st != S_IDLE;
  assign done    = r_done;
  assign ovf_err = r_ovf;
  assign res     = r_res;
  always_ff @(posedge clk) begin
    if (w_push && !abort) begin
      r_dat[r_wp[AW-1:0]] <= w_wd;
      r_lst[r_wp[AW-1:0]] <= wr_last;
      r_msk[r_wp[AW-1:0]] <= w_wm;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= S_IDLE;
      r_wp   <= '0;
      r_rp   <= '0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_res  <= '0;
    end else if (abort) begin
      r_st   <= S_IDLE;
      r_wp   <= '0;
      r_rp   <= '0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop) r_rp <= r_rp + (AW+1)'(1);
      if (wr_en && fifo_full) r_ovf <= 1'b1;
      if (r_st == S_IDLE && !w_empty) begin
        r_st   <= S_FEED;
        r_done <= 1'b0;
      end
      if (w_pop && r_lst[w_hd]) r_st <= S_WAIT;
      if (r_st == S_WAIT && cmprss_otpt_vld) begin
        r_res  <= cmprss_otpt_res;
        r_done <= 1'b1;
        r_st   <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_sm3_msg_feeder.sv
// tb_sm3_msg_feeder: scoreboard bench for sm3_msg_feeder with an emulated core and reference model.
module tb_sm3_msg_feeder;
  localparam int DW = 32, BW = 4, DEPTH = 8;
  localparam logic [255:0] D1 = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] D2 = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
  logic clk = 0, rst = 1;
  logic wr_en = 0, wr_last = 0, abort = 0, msg_inpt_rdy = 0, cmprss_otpt_vld = 0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0] wr_nbyte = '0;
  logic [255:0] cmprss_otpt_res = '0;
  logic fifo_full, ovf_err, busy, done, msg_inpt_vld, msg_inpt_lst;
  logic [3:0] fifo_cnt;
  logic [255:0] res;
  logic [DW-1:0] msg_inpt_d;
  logic [BW-1:0] msg_inpt_vld_byte;

  sm3_msg_feeder #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last), .wr_nbyte(wr_nbyte),
    .abort(abort), .fifo_full(fifo_full), .fifo_cnt(fifo_cnt), .ovf_err(ovf_err), .busy(busy),
    .done(done), .res(res), .msg_inpt_d(msg_inpt_d), .msg_inpt_vld_byte(msg_inpt_vld_byte),
    .msg_inpt_vld(msg_inpt_vld), .msg_inpt_lst(msg_inpt_lst), .msg_inpt_rdy(msg_inpt_rdy),
    .cmprss_otpt_res(cmprss_otpt_res), .cmprss_otpt_vld(cmprss_otpt_vld)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, lst_cnt = 0;
  bit core_auto = 0, rdy_rand = 0, fixed_use = 0;
  logic [255:0] fixed_res = '0, model_res = '0;
  logic [DW+BW:0] exp_beat [$];
  logic [255:0] exp_res [$];

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] bsw(logic [31:0] w);
`ifdef SM3_FEED_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // top n bytes valid; a last word with n=0, or any non-last word, carries BW bytes
  function automatic logic [BW-1:0] model_mask(logic l, logic [1:0] n);
    int k = (l && n != 0) ? int'(n) : BW;
    logic [BW-1:0] m = '0;
    for (int i = 0; i < k; i++) m[BW-1-i] = 1'b1;
    return m;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] w, input logic l, input logic [1:0] n, input bit acc);
    wr_en = 1; wr_data = w; wr_last = l; wr_nbyte = n;
    if (acc) exp_beat.push_back({bsw(w), model_mask(l, n), l});
    cyc();
    wr_en = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_beat.size() != 0 || exp_res.size() != 0 || busy || lst_cnt != 0) && t < 3000) begin
      cyc(); t++;
    end
    chk("drain_timeout", 256'(t < 3000), 256'(1));
  endtask

  // emulated core: ready pattern and a digest pulse some cycles after each last beat
  initial begin
    forever begin
      cyc();
      if (core_auto) begin
        cmprss_otpt_vld = 0;
        msg_inpt_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (lst_cnt > 0 && $urandom_range(0, 2) == 0) begin
          lst_cnt--;
          if (fixed_use) cmprss_otpt_res = fixed_res;
          else for (int k = 0; k < 8; k++) cmprss_otpt_res[32*k +: 32] = $urandom;
          cmprss_otpt_vld = 1;
          exp_res.push_back(cmprss_otpt_res);
        end
      end
    end
  end

  // monitor: checks every accepted beat, handshake stability and each completed digest
  logic prev_stall = 0, prev_done = 0;
  logic [DW-1:0] prev_d = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("vld_held", 256'(msg_inpt_vld), 256'(1));
        chk("d_held", 256'(msg_inpt_d), 256'(prev_d));
      end
      if (msg_inpt_vld && msg_inpt_rdy) begin
        if (exp_beat.size() == 0) chk("unexpected_beat", 256'(msg_inpt_d), 256'(0) - 1);
        else chk("beat", 256'({msg_inpt_d, msg_inpt_vld_byte, msg_inpt_lst}), 256'(exp_beat.pop_front()));
        if (msg_inpt_lst) lst_cnt++;
      end
      if (done && !prev_done) begin
        if (exp_res.size() == 0) chk("unexpected_done", res, ~res);
        else begin
          model_res = exp_res.pop_front();
          chk("digest", res, model_res);
        end
      end
      prev_stall = msg_inpt_vld && !msg_inpt_rdy && !abort;
      prev_d = msg_inpt_d;
      prev_done = done;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0;
    int t;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_busy", 256'(busy), 0);
    chk("rst_done", 256'(done), 0);
    chk("rst_cnt", 256'(fifo_cnt), 0);
    chk("rst_full", 256'(fifo_full), 0);
    chk("rst_ovf", 256'(ovf_err), 0);
    chk("rst_vld", 256'(msg_inpt_vld), 0);
    chk("rst_res", res, 0);
    cyc();
    rst = 0;
    cyc();
    // "abc"
    core_auto = 1; rdy_rand = 0; fixed_use = 1; fixed_res = D1;
    wr(bsw(32'h61626300), 1, 2'd3, 1);
    drain();
    @(negedge clk);
    chk("abc_done", 256'(done), 1);
    chk("abc_res", res, D1);
    cyc();
    // 64-byte "abcd" x16
    fixed_res = D2;
    for (int i = 0; i < 16; i++) wr(bsw(32'h61626364), 1'(i == 15), 2'd0, 1);
    drain();
    @(negedge clk);
    chk("abcd_res", res, D2);
    cyc();
    // backpressure: 5 stalled cycles mid-message
    fixed_use = 0;
    core_auto = 0; msg_inpt_rdy = 0;
    w0 = $urandom;
    wr(w0, 0, 0, 1);
    wr($urandom, 0, 0, 1);
    wr($urandom, 1, 2'($urandom_range(0, 3)), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", 256'(msg_inpt_vld), 1);
      chk("bp_d", 256'(msg_inpt_d), 256'(bsw(w0)));
      chk("bp_cnt", 256'(fifo_cnt), 3);
      cyc();
    end
    rdy_rand = 1; core_auto = 1;
    drain();
    // overflow: DEPTH+1 writes with ready low, the extra word is lost
    core_auto = 0; msg_inpt_rdy = 0;
    for (int i = 0; i <= DEPTH; i++) wr($urandom, 1'(i == DEPTH - 1), 2'($urandom_range(0, 3)), i < DEPTH);
    @(negedge clk);
    chk("ovf_full", 256'(fifo_full), 1);
    chk("ovf_cnt", 256'(fifo_cnt), DEPTH);
    chk("ovf_err", 256'(ovf_err), 1);
    cyc();
    core_auto = 1;
    drain();
    // abort in WAIT_RES together with the result pulse
    core_auto = 0; msg_inpt_rdy = 1; cmprss_otpt_vld = 0;
    wr($urandom, 1, 0, 1);
    t = 0;
    while (lst_cnt == 0 && t < 50) begin cyc(); t++; end
    chk("abort_reach_wait", 256'(t < 50), 1);
    chk("abort_busy_pre", 256'(busy), 1);
    for (int k = 0; k < 8; k++) cmprss_otpt_res[32*k +: 32] = $urandom;
    cmprss_otpt_vld = 1; abort = 1;
    exp_beat.delete(); lst_cnt = 0;
    cyc();
    cmprss_otpt_vld = 0; abort = 0;
    @(negedge clk);
    chk("abort_done", 256'(done), 0);
    chk("abort_busy", 256'(busy), 0);
    chk("abort_res", res, model_res);
    chk("abort_ovf", 256'(ovf_err), 0);
    chk("abort_cnt", 256'(fifo_cnt), 0);
    chk("abort_vld", 256'(msg_inpt_vld), 0);
    cyc();
    // randomized messages with random gaps and random ready
    core_auto = 1; rdy_rand = 1;
    for (int m = 0; m < 25; m++) begin
      int len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) cyc();
        t = 0;
        while (fifo_full && t < 200) begin cyc(); t++; end
        if (t >= 200) chk("full_timeout", 256'(t), 0);
        wr($urandom, 1'(i == len - 1), 2'($urandom_range(0, 3)), 1);
      end
    end
    drain();
    chk("beats_left", 256'(exp_beat.size()), 0);
    chk("res_left", 256'(exp_res.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
